pdm_cic_decimator: RTL

Receive-side counterpart of the sigma-delta DAC path. The block takes a 1-bit PDM stream, for example the `sigma_delta_modulator` output looped back or an external PDM source. It decimates that stream through a 4th-order CIC filter to signed 16-bit PCM, one sample per DECIM enabled input bits (44.1 kHz for 5.6448 MHz / 128). Output is a registered valid/ready sample port with overrun and saturation reporting, for loopback checking of the DAC chain and for PDM capture.

---
 rtl/pdm_cic_decimator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM decimator: 4th-order CIC (differential delay 1), saturating
// scale stage and a single-entry valid/ready output register.
module pdm_cic_decimator #(
  parameter int unsigned DECIM = 128,
  parameter int unsigned OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pdm_en,
  input  logic                    pdm_in,
  output logic signed [OUT_W-1:0] pcm_data,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    pcm_sat,
  output logic                    overrun
);

  localparam int unsigned ORDER  = 4;
  localparam int unsigned LOG2D  = $clog2(DECIM);
  localparam int unsigned ACC_W  = 2 + ORDER * LOG2D;
  localparam int          SHIFT  = int'(ORDER * LOG2D) - int'(OUT_W - 1);
  localparam int unsigned RSH    = (SHIFT > 0) ? SHIFT : 0;
  localparam int unsigned LSH    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int unsigned EXT_W  = ACC_W + OUT_W;
  localparam int unsigned WARM_N = 5;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0]        r_integ [ORDER];
  logic [ACC_W-1:0]        r_cdly  [ORDER];
  logic [LOG2D-1:0]        r_dcnt;
  logic                    r_tick_d;
  logic [2:0]              r_warm;
  logic signed [OUT_W-1:0] r_pcm_data;
  logic                    r_pcm_valid;
  logic                    r_pcm_sat;
  logic                    r_overrun;

  logic [ACC_W-1:0]        w_step;
  logic                    w_tick;
  logic [ACC_W-1:0]        w_c1, w_c2, w_c3, w_c4;
  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_res;
  logic signed [OUT_W-1:0] w_pcm;
  logic                    w_sat;
  logic                    w_new;

  assign w_step = pdm_in ? {{(ACC_W-1){1'b0}}, 1'b1} : '1;
  assign w_tick = pdm_en && (r_dcnt == LOG2D'(DECIM - 1));

  // Integrators wrap modulo 2^ACC_W; the comb differences recover exact values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_integ <= '{default: '0};
      r_dcnt  <= '0;
    end else if (pdm_en) begin
      r_integ[0] <= r_integ[0] + w_step;
      for (int unsigned k = 1; k < ORDER; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  assign w_c1 = r_integ[ORDER-1] - r_cdly[0];
  assign w_c2 = w_c1 - r_cdly[1];
  assign w_c3 = w_c2 - r_cdly[2];
  assign w_c4 = w_c3 - r_cdly[3];

  // Comb runs the cycle after the tick; r_integ is stable for that whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdly   <= '{default: '0};
      r_tick_d <= 1'b0;
      r_warm   <= '0;
    end else begin
      r_tick_d <= w_tick;
      if (r_tick_d) begin
        r_cdly[0] <= r_integ[ORDER-1];
        r_cdly[1] <= w_c1;
        r_cdly[2] <= w_c2;
        r_cdly[3] <= w_c3;
        if (r_warm != 3'(WARM_N)) r_warm <= r_warm + 3'd1;
      end
    end
  end

  assign w_ext = {{OUT_W{w_c4[ACC_W-1]}}, w_c4};
  assign w_res = (w_ext >>> RSH) <<< LSH;

  always_comb begin
    w_pcm = w_res[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_res > SAT_MAX) begin
      w_pcm = {1'b0, {(OUT_W-1){1'b1}}};
      w_sat = 1'b1;
    end else if (w_res < SAT_MIN) begin
      w_pcm = {1'b1, {(OUT_W-1){1'b0}}};
      w_sat = 1'b1;
    end
  end

  assign w_new = r_tick_d && (r_warm == 3'(WARM_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcm_data  <= '0;
      r_pcm_valid <= 1'b0;
      r_pcm_sat   <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_new) begin
      r_pcm_data  <= w_pcm;
      r_pcm_sat   <= w_sat;
      r_pcm_valid <= 1'b1;
      if (r_pcm_valid && !pcm_ready) r_overrun <= 1'b1;
    end else if (r_pcm_valid && pcm_ready) begin
      r_pcm_valid <= 1'b0;
    end
  end

  assign pcm_data  = r_pcm_data;
  assign pcm_valid = r_pcm_valid;
  assign pcm_sat   = r_pcm_sat;
  assign overrun   = r_overrun;

endmodule
